// File: rtl/fft_pkg.sv
// Shared FFT datapath helpers.
// - Width constants for the full-precision twiddle product and sum.
// - Upper/lower half extraction of packed complex words, sign-extended.
// - Round-half-up scaling followed by saturation to a signed output width.
// Helpers work on 64-bit containers so one definition serves every width.
package fft_pkg;

   typedef struct packed {
      logic signed [63:0] val;
      logic               sat;
   } rs_t;

   // Width of one real product: the coefficient is carried one bit wider
   // so that negating its most negative value cannot wrap.
   function automatic int prod_w(input int nb, input int nc);
      return nb + nc + 1;
   endfunction

   // Width of a sum/difference of two products; no overflow is possible.
   function automatic int sum_w(input int nb, input int nc);
      return nb + nc + 2;
   endfunction

   // Upper component of a packed pair of w-bit fields, sign-extended.
   function automatic logic signed [63:0] upper_half(input logic [63:0] v, input int w);
      logic signed [63:0] t;
      t = signed'(v << (64 - 2 * w));
      return t >>> (64 - w);
   endfunction

   // Lower component of a packed pair of w-bit fields, sign-extended.
   function automatic logic signed [63:0] lower_half(input logic [63:0] v, input int w);
      logic signed [63:0] t;
      t = signed'(v << (64 - w));
      return t >>> (64 - w);
   endfunction

   // Add half an LSB, arithmetic shift right, then clamp to nout bits.
   function automatic rs_t round_sat(input logic signed [63:0] x, input int shift,
                                     input int nout);
      logic signed [63:0] r;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      rs_t                o;
      r     = (x + (64'sd1 <<< (shift - 1))) >>> shift;
      hi    = (64'sd1 <<< (nout - 1)) - 64'sd1;
      lo    = -(64'sd1 <<< (nout - 1));
      o.val = r;
      o.sat = 1'b0;
      if (r > hi) begin
         o.val = hi;
         o.sat = 1'b1;
      end else if (r < lo) begin
         o.val = lo;
         o.sat = 1'b1;
      end
      return o;
   endfunction

endpackage

// File: rtl/multip_tdw_round_sat.sv
// Combinational round/saturate of one complex component.
// Ports:
//   din  - full-precision signed value (IN_W bits)
//   dout - value scaled by 2^-SHIFT (round half up), clamped to OUT_W bits
//   sat  - 1 when the clamp was applied
module multip_tdw_round_sat
   import fft_pkg::*;
#(
   parameter int IN_W  = 23,
   parameter int SHIFT = 9,
   parameter int OUT_W = 11
) (
   input  logic signed [IN_W-1:0]  din,
   output logic signed [OUT_W-1:0] dout,
   output logic                    sat
);

   rs_t rs;

   always_comb begin
      rs   = round_sat(64'(din), SHIFT, OUT_W);
      dout = OUT_W'(rs.val);
      sat  = rs.sat;
   end

endmodule

// File: rtl/multip_tdw_pipe.sv
// Pipelined complex twiddle multiplier with valid/ready handshake.
// S1 registers the operands (optionally conjugating the coefficient),
// S2 registers the four partial products, S3 registers the rounded and
// saturated complex result.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid / in_ready  - input handshake for muestra, coeff, conj_in
//   muestra              - sample, real in upper half, imag in lower half
//   coeff                - twiddle, real in upper half, imag in lower half
//   conj_in              - multiply by conj(coeff)
//   out_valid / out_ready- output handshake for result, out_sat
//   result               - scaled product, real upper, imag lower
//   out_sat              - some component of result was clamped
//   sat_sticky/sat_clear - accumulated saturation flag and its clear
module multip_tdw_pipe
   import fft_pkg::*;
#(
   parameter int NBITS      = 10,
   parameter int NBITScoeff = 11,
   parameter int SHIFT      = NBITScoeff - 2,
   parameter int NBITS_out  = NBITS + 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2*NBITS-1:0]       muestra,
   input  logic [2*NBITScoeff-1:0]  coeff,
   input  logic                     conj_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [2*NBITS_out-1:0]   result,
   output logic                     out_sat,
   output logic                     sat_sticky,
   input  logic                     sat_clear
);

   localparam int CW = NBITScoeff + 1;
   localparam int PW = prod_w(NBITS, NBITScoeff);
   localparam int SW = sum_w(NBITS, NBITScoeff);

   logic vld_p1, vld_p2, vld_p3;
   logic adv1, adv2, adv3;

   logic signed [NBITS-1:0] mr_in, mi_in;
   logic signed [CW-1:0]    cr_in, ci_ext, ci_in;

   logic signed [NBITS-1:0] mr_p1, mi_p1;
   logic signed [CW-1:0]    cr_p1, ci_p1;

   logic signed [PW-1:0]    rr_p2, ii_p2, ri_p2, ir_p2;

   logic signed [SW-1:0]        re_full, im_full;
   logic signed [NBITS_out-1:0] re_rs, im_rs;
   logic                        re_sat, im_sat;

   // Stage advance: a stage may load when the one after it moves or it is empty.
   assign adv3      = out_ready || !vld_p3;
   assign adv2      = adv3 || !vld_p2;
   assign adv1      = adv2 || !vld_p1;
   assign in_ready  = adv1;
   assign out_valid = vld_p3;

   always_comb begin
      mr_in  = NBITS'(upper_half(64'(muestra), NBITS));
      mi_in  = NBITS'(lower_half(64'(muestra), NBITS));
      cr_in  = CW'(upper_half(64'(coeff), NBITScoeff));
      ci_ext = CW'(lower_half(64'(coeff), NBITScoeff));
      ci_in  = conj_in ? -ci_ext : ci_ext;
   end

   // ---- S1: operand registers ----
   always_ff @(posedge clk) begin
      if (adv1) begin
         mr_p1 <= mr_in;
         mi_p1 <= mi_in;
         cr_p1 <= cr_in;
         ci_p1 <= ci_in;
      end
   end

   // ---- S2: partial product registers ----
   always_ff @(posedge clk) begin
      if (adv2) begin
         rr_p2 <= PW'(mr_p1) * PW'(cr_p1);
         ii_p2 <= PW'(mi_p1) * PW'(ci_p1);
         ri_p2 <= PW'(mr_p1) * PW'(ci_p1);
         ir_p2 <= PW'(mi_p1) * PW'(cr_p1);
      end
   end

   // ---- S3: complex sum, scale, saturate ----
   always_comb begin
      re_full = SW'(rr_p2) - SW'(ii_p2);
      im_full = SW'(ri_p2) + SW'(ir_p2);
   end

   multip_tdw_round_sat #(.IN_W(SW), .SHIFT(SHIFT), .OUT_W(NBITS_out)) u_rs_re (
      .din  (re_full),
      .dout (re_rs),
      .sat  (re_sat)
   );

   multip_tdw_round_sat #(.IN_W(SW), .SHIFT(SHIFT), .OUT_W(NBITS_out)) u_rs_im (
      .din  (im_full),
      .dout (im_rs),
      .sat  (im_sat)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1     <= 1'b0;
         vld_p2     <= 1'b0;
         vld_p3     <= 1'b0;
         result     <= '0;
         out_sat    <= 1'b0;
         sat_sticky <= 1'b0;
      end else begin
         if (adv1) vld_p1 <= in_valid;
         if (adv2) vld_p2 <= vld_p1;
         if (adv3) begin
            vld_p3  <= vld_p2;
            result  <= {re_rs, im_rs};
            out_sat <= re_sat || im_sat;
         end
         // A saturated transfer in the same cycle as a clear keeps the flag set.
         sat_sticky <= (sat_sticky && !sat_clear) || (vld_p3 && out_ready && out_sat);
      end
   end

endmodule

// File: tb/tb_multip_tdw_pipe.sv
module tb_multip_tdw_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [19:0] muestra = '0;
   logic [21:0] coeff = '0;
   logic        conj_in = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [21:0] result;
   logic        out_sat;
   logic        sat_sticky;
   logic        sat_clear = 1'b0;

   logic signed [10:0] re_o, im_o;
   assign re_o = result[21:11];
   assign im_o = result[10:0];

   int n_cmp = 0;
   int n_bad = 0;

   multip_tdw_pipe dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .muestra    (muestra),
      .coeff      (coeff),
      .conj_in    (conj_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .out_sat    (out_sat),
      .sat_sticky (sat_sticky),
      .sat_clear  (sat_clear)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic signed [63:0] got,
                      input logic signed [63:0] exp);
      n_cmp++;
      assert (got === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic drive(input int mr, input int mi, input int cr, input int ci,
                        input logic cj);
      muestra = {10'(mr), 10'(mi)};
      coeff   = {11'(cr), 11'(ci)};
      conj_in = cj;
   endtask

   // Independent golden model: integer products, floor division for rounding.
   function automatic int rnd_clamp(input longint x, output logic s);
      longint v, q;
      v = x + 256;
      q = (v >= 0) ? v / 512 : -((-v + 511) / 512);
      s = 1'b0;
      if (q > 1023) begin q = 1023; s = 1'b1; end
      if (q < -1024) begin q = -1024; s = 1'b1; end
      return int'(q);
   endfunction

   function automatic void model(input int mr, input int mi, input int cr, input int ci,
                                 input logic cj, output int re, output int im,
                                 output logic s);
      longint c2;
      logic   s1, s2;
      c2 = cj ? -ci : ci;
      re = rnd_clamp(longint'(mr) * cr - longint'(mi) * c2, s1);
      im = rnd_clamp(longint'(mr) * c2 + longint'(mi) * cr, s2);
      s  = s1 | s2;
   endfunction

   // One transaction with out_ready high; checks 3-cycle latency and value.
   task automatic directed(input string tag, input int mr, input int mi, input int cr,
                           input int ci, input logic cj, input int ere, input int eim,
                           input logic esat);
      @(posedge clk); #1;
      drive(mr, mi, cr, ci, cj);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      chk({tag, " in_ready"}, in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk({tag, " lat1 out_valid"}, out_valid, 0);
      @(posedge clk); #1;
      chk({tag, " lat2 out_valid"}, out_valid, 0);
      @(posedge clk); #1;
      chk({tag, " out_valid"}, out_valid, 1);
      chk({tag, " re"}, re_o, ere);
      chk({tag, " im"}, im_o, eim);
      chk({tag, " out_sat"}, out_sat, esat);
   endtask

   int   t_mr [10] = '{100, -300, 511, -512, 7, -1, 250, -128, 400, -77};
   int   t_mi [10] = '{-50, 200, 511, -512, 9, -1, -250, 64, -400, 33};
   int   t_cr [10] = '{512, -362, 1023, -1024, 300, -1024, 362, -700, 1000, 511};
   int   t_ci [10] = '{0, 362, 1023, -1024, -300, 1, -362, 700, -1000, -5};
   logic t_cj [10] = '{0, 1, 0, 1, 0, 1, 1, 0, 1, 0};

   initial begin
      int          sent, rcv, ere, eim;
      logic        esat, hold_v;
      logic [21:0] held;

      // Reset state
      #2;
      chk("rst out_valid", out_valid, 0);
      chk("rst result", result, 0);
      chk("rst out_sat", out_sat, 0);
      chk("rst sat_sticky", sat_sticky, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst in_ready", in_ready, 1);

      directed("identity", 100, 50, 512, 0, 1'b0, 100, 50, 1'b0);
      directed("conj0", 0, 100, 0, 512, 1'b0, -100, 0, 1'b0);
      directed("conj1", 0, 100, 0, 512, 1'b1, 100, 0, 1'b0);
      directed("rnd_pos1", 1, 0, 256, 0, 1'b0, 1, 0, 1'b0);
      directed("rnd_neg1", -1, 0, 256, 0, 1'b0, 0, 0, 1'b0);
      directed("rnd_3", 3, 0, 256, 0, 1'b0, 2, 0, 1'b0);
      chk("sticky before sat", sat_sticky, 0);

      directed("sat", -512, -512, -1024, -1024, 1'b0, 0, 1023, 1'b1);
      @(posedge clk); #1;
      chk("sat sticky set", sat_sticky, 1);
      sat_clear = 1'b1;
      @(posedge clk); #1;
      sat_clear = 1'b0;
      chk("sat sticky cleared", sat_sticky, 0);

      // Backpressure stream with random in_valid/out_ready
      sent   = 0;
      rcv    = 0;
      hold_v = 1'b0;
      held   = '0;
      for (int cyc = 0; cyc < 400 && rcv < 10; cyc++) begin
         @(posedge clk); #1;
         if (sent < 10) begin
            drive(t_mr[sent], t_mi[sent], t_cr[sent], t_ci[sent], t_cj[sent]);
            in_valid = ($urandom_range(0, 3) != 0);
         end else begin
            in_valid = 1'b0;
         end
         out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (hold_v) begin
            chk("bp hold out_valid", out_valid, 1);
            chk("bp hold result", result, held);
         end
         chk("bp in_ready", in_ready, !((sent - rcv) == 3 && !out_ready));
         if (out_valid && out_ready) begin
            model(t_mr[rcv], t_mi[rcv], t_cr[rcv], t_ci[rcv], t_cj[rcv], ere, eim, esat);
            chk("bp re", re_o, ere);
            chk("bp im", im_o, eim);
            chk("bp out_sat", out_sat, esat);
            rcv++;
         end
         if (in_valid && in_ready) sent++;
         hold_v = out_valid && !out_ready;
         held   = result;
      end
      chk("bp received count", rcv, 10);
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("bp no duplicate", out_valid, 0);

      // Async reset with three samples in flight
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      drive(100, 50, 512, 0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("full out_valid", out_valid, 1);
      chk("full in_ready", in_ready, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async rst out_valid", out_valid, 0);
      chk("async rst result", result, 0);
      chk("async rst in_ready", in_ready, 1);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("post rst idle", out_valid, 0);
      end
      directed("post rst", -200, 30, 512, 0, 1'b0, -200, 30, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/multip_tdw_pipe.md
# multip_tdw_pipe

Pipelined, parametrised complex twiddle multiplier for the FFT butterfly datapath. It replaces the combinational full-width twiddle product with a 3-stage registered multiplier. The block adds a valid/ready handshake, per-sample conjugation of the coefficient for inverse transforms, round-half-up scaling, and saturation to a programmable output width. It sits between the stage delay-commutator and the next butterfly, one instance per parallel lane.

## Interface
- NBITS, 10: signed width of each sample component (real, imag).
- NBITScoeff, 11: signed width of each coefficient component.
- SHIFT, NBITScoeff-2: number of coefficient fractional bits. Legal range 1 to NBITS+NBITScoeff-1.
- NBITS_out, NBITS+1: signed width of each output component after scaling.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  sample/coefficient pair present.
- in_ready  out  1  block accepts the pair this cycle.
- muestra  in  2*NBITS  sample; real in [2*NBITS-1:NBITS], imag in [NBITS-1:0].
- coeff  in  2*NBITScoeff  twiddle; real in the upper half, imag in the lower half.
- conj_in  in  1  1 = multiply by conj(coeff), for the IFFT.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- result  out  2*NBITS_out  scaled product; real in the upper half, imag in the lower half.
- out_sat  out  1  result has at least one saturated component.
- sat_sticky  out  1  OR of all out_sat since reset or since the last clear.
- sat_clear  in  1  synchronous clear of sat_sticky.

## Operation
- Transfer rule: in on in_valid&&in_ready; out on out_valid&&out_ready.
- Stage S1 registers muestra, coeff and conj_in.
  - If conj_in is set, the coefficient imag is negated.
  - Negating −2^(NBITScoeff−1) uses NBITScoeff+1 bits, so there is no wrap.
- Stage S2 registers the four signed products: mr·cr, mi·ci, mr·ci, mi·cr. Each is NBITS+NBITScoeff+1 bits.
- Stage S3 computes the full-width results:
  - re = mr·cr − mi·ci
  - im = mr·ci + mi·cr
  - Both are computed at NBITS+NBITScoeff+2 bits, so no intermediate overflow is possible.
- Scaling in S3: add 2^(SHIFT−1), then arithmetic right shift by SHIFT. This is round-half-toward-+∞.
- Saturation in S3: clamp each component to [−2^(NBITS_out−1), 2^(NBITS_out−1)−1].
  - out_sat = clamp applied to re or im.
- S3 registers result and out_sat.
- All operands are explicitly signed. Every product and sum is sign-extended to full width before the operation.
- Pipeline advance, with v1..v3 the stage valid bits:
  - adv3 = out_ready || !v3
  - adv2 = adv3 || !v2
  - adv1 = adv2 || !v1
  - in_ready = adv1
  - Each stage loads when its advance is high; its valid takes the upstream valid.
- Stall: with out_ready low, result, out_sat and out_valid hold stable. Data registers in a stalled stage do not change.
- sat_sticky update each cycle:
  - sticky ← (sticky && !sat_clear) || (out_valid && out_ready && out_sat)
  - If a clear and a saturated transfer coincide, the new saturation wins: sticky stays 1.

## Timing
- Latency: 3 cycles from input transfer to out_valid, with no stall.
- Throughput: 1 result per cycle while out_ready is held high.
- Reset values: v1..v3 = 0, out_valid = 0, result = 0, out_sat = 0, sat_sticky = 0.
  - in_ready is 1 once reset is released (it is combinational from the valid bits).
- Reset asserted mid-operation: all in-flight data is discarded immediately, without waiting for a clock edge. No spurious out_valid appears after release.
- in_ready depends combinationally on out_ready; that is the only combinational input-to-output path.
- Simultaneous input accept and output drain on a full pipe is legal and loses nothing.

## Structure
- Shared package fft_pkg holds:
  - the packing helpers (upper/lower half extraction functions);
  - the saturate-and-round function, parametrised by input width, SHIFT and NBITS_out;
  - the full-product width constants.
- One natural sub-module, multip_tdw_round_sat: a combinational round/saturate of one component, instanced twice in S3.
- The handshake logic stays in the top level.

## Test plan
All cases use the defaults, so SHIFT=9, 1.0 = 512 and NBITS_out=11.
- Identity: muestra=(100,50), coeff=(512,0), conj_in=0 → result=(100,50), out_sat=0, 3 cycles after accept.
- Conjugation: muestra=(0,100), coeff=(0,512). With conj_in=0 → (−100,0). With conj_in=1 → (100,0).
- Rounding:
  - (1,0)×(256,0) → (1,0).
  - (−1,0)×(256,0) → (0,0).
  - (3,0)×(256,0) → (2,0).
- Saturation: muestra=(−512,−512), coeff=(−1024,−1024) → result=(0,1023), out_sat=1, sat_sticky=1. Next cycle, sat_clear=1 with no saturated transfer → sat_sticky=0.
- Backpressure:
  - Stream 10 random vectors with out_ready toggling randomly.
  - Results must match a golden model in order, with none dropped or duplicated.
  - result must stay stable while out_valid=1 and out_ready=0.
  - in_ready=0 only when all 3 stages are full and out_ready=0.
- Async reset: assert rst_n=0 between clock edges with 3 samples in flight → out_valid=0 immediately. After release, the first output comes only from a new input, 3 cycles later.
